picorv_memarb: RTL and testbench
================================

Name: picorv_memarb

Overview:
- Shares the single PicoRV memory port between NREQ requesters (e.g. instruction fetch, load/store unit, debug) that use the reqst/grant + valid/ready protocol.
- Registered grant; ownership is held for the whole reqst window, so a requester can issue back-to-back transactions without re-arbitrating.
- Sits between the core's memory-side units and the external memory/bus bridge.

Parameters:
- XLEN, 32, address width.
- NREQ, 2, number of requesters (2..8); index 0 is highest fixed priority.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- req_reqst  in  NREQ  per-requester bus request.
- req_grant  out  NREQ  per-requester grant, one-hot or zero, registered.
- req_valid  in  NREQ  per-requester transaction valid.
- req_ready  out  NREQ  per-requester completion; only the owner's bit can be 1.
- req_addr  in  NREQ*XLEN  packed addresses, requester i at [i*XLEN +: XLEN].
- req_wdata  in  NREQ*32  packed write data.
- req_wstrb  in  NREQ*4  packed byte strobes; 0 means read.
- req_rdata  out  32  read data, broadcast from mem_rdata.
- mem_valid  out  1  downstream valid.
- mem_ready  in  1  downstream ready.
- mem_addr  out  XLEN  downstream address.
- mem_wdata  out  32  downstream write data.
- mem_wstrb  out  4  downstream strobes.
- mem_rdata  in  32  downstream read data.
- proto_err  out  1  sticky flag for a protocol violation by any requester.

Behaviour:
- States: IDLE (no owner) and OWNED(owner index). Owner index is a registered clog2(NREQ)-bit value.
- Reset values: state IDLE; req_grant 0; proto_err 0; rotate pointer 0. In IDLE, mem_valid is 0 and mem_addr, mem_wdata and mem_wstrb are 0.
- IDLE with any req_reqst set: choose a winner and go to OWNED(winner). req_grant[winner] is 1 from the next cycle. Request-to-grant latency is 1 cycle.
- OWNED, datapath:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are combinational muxes of the owner's req_* signals.
  - req_ready[owner] = mem_ready && req_valid[owner].
  - req_rdata = mem_rdata at all times.
- OWNED, release condition: req_reqst[owner] == 0 && req_valid[owner] == 0, evaluated each cycle.
  - On release with other requests pending, go directly to OWNED(next winner). The new grant appears the next cycle with no idle gap.
  - On release with nothing pending, go to IDLE.
- Owner drops req_reqst while its req_valid is high and the transaction is not yet accepted: ownership is held until the valid&&ready handshake completes. proto_err is set.
- Non-owner raises req_valid: ignored (its req_ready stays 0, nothing is forwarded) and proto_err is set.
- Simultaneous events:
  - Release and a new request arriving in the same cycle: the new request takes part in that cycle's arbitration.
  - The owner's own reqst in the release cycle is 0 by definition, so it cannot re-win.
- Fixed-priority mode (default): the lowest index with reqst set wins.
- Reset mid-transaction: immediately drops grant and mem_valid. Any downstream acceptance in flight is the bridge's responsibility.
- Downstream mem_ready seen while mem_valid is 0 is ignored.

Optional Feature:
- Macro PICORV_MEMARB_RR_EN.
- Defined: round-robin arbitration. A rotate pointer is set to owner+1 (mod NREQ) on each grant; the search starts at the pointer and wraps around.
- Undefined: fixed priority, index 0 highest; the pointer register is not built.

Decomposition:
- Shared package picorv_pkg: arbiter state enum (ARB_IDLE, ARB_OWNED) and a function computing the owner-index width from NREQ.
- One sub-module, picorv_memarb_pick: combinational picker taking a request vector and start pointer, returning a valid flag and a winner index; it has no state.
- The FSM, muxes and the proto_err flag stay in picorv_memarb.

Test Plan:
- Single requester: req_reqst[1]=1 in cycle 0 → req_grant=2'b10 in cycle 1. Read of addr 0x100 with mem_ready after 2 wait cycles → req_ready[1] pulses 1 cycle, req_rdata=mem_rdata=0xDEADBEEF.
- Contention, fixed priority: reqst[0] and reqst[1] raised in the same cycle → grant 01. After requester 0 drops reqst, grant 10 the next cycle with no IDLE cycle in between.
- Round robin (PICORV_MEMARB_RR_EN): both requesters hold reqst and each does one transaction then drops for 1 cycle and re-raises → grants alternate 01, 10, 01, 10.
- Burst ownership: requester 0 keeps reqst high for 3 back-to-back writes (wstrb 4'b1111, 4'b0011, 4'b1000) while requester 1 requests → all 3 forwarded in order before grant moves to 10.
- Protocol error: requester 1 raises req_valid without grant → mem_valid is unaffected, req_ready[1]=0, proto_err=1 and stays 1 until reset.
- Async reset asserted mid-wait (mem_valid=1, mem_ready=0) → req_grant=0, mem_valid=0 and proto_err=0 in the same cycle, before the next clock edge.

Source files
------------

// File: rtl/picorv_pkg.sv
// Shared types for the PicoRV memory-port arbiter: FSM state encoding and
// the owner-index width helper.
package picorv_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  // Owner index is at least one bit wide, even for a two-requester build.
  function automatic int owner_width(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/picorv_memarb_pick.sv
// Stateless request picker: scans the request vector starting at 'start',
// wrapping around, and returns the first set index.
module picorv_memarb_pick
  import picorv_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int OW   = owner_width(NREQ)
) (
  input  logic [NREQ-1:0] reqs,
  input  logic [OW-1:0]   start,
  output logic            found,
  output logic [OW-1:0]   winner
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start) + k) % NREQ;
      if (!found && reqs[idx]) begin
        found  = 1'b1;
        winner = idx[OW-1:0];
      end
    end
  end

endmodule

// File: rtl/picorv_memarb.sv
// Arbiter sharing one PicoRV memory port between NREQ requesters.
// Define PICORV_MEMARB_RR_EN for round-robin; default is fixed priority (0 highest).
module picorv_memarb
  import picorv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_reqst,
  output logic [NREQ-1:0]      req_grant,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]    req_wstrb,
  output logic [31:0]          req_rdata,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [XLEN-1:0]      mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata,
  output logic                 proto_err
);

  localparam int OW = owner_width(NREQ);

  arb_state_e      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            err_q, err_d;
  logic            owned, owner_reqst, release_now, take;
  logic            pick_found;
  logic [OW-1:0]   pick_winner, pick_start;

  assign owned     = (state_q == ARB_OWNED);
  assign req_grant = grant_q;
  assign proto_err = err_q;
  assign req_rdata = mem_rdata;
  assign req_ready = grant_q & req_valid & {NREQ{mem_ready}};

  // Forward the owner's channel; everything reads as zero while idle.
  always_comb begin
    mem_valid   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    owner_reqst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owned && owner_q == i[OW-1:0]) begin
        mem_valid   = req_valid[i];
        mem_addr    = req_addr[i*XLEN +: XLEN];
        mem_wdata   = req_wdata[i*32 +: 32];
        mem_wstrb   = req_wstrb[i*4 +: 4];
        owner_reqst = req_reqst[i];
      end
    end
  end

  // A pending valid keeps ownership even after reqst drops.
  assign release_now = owned && !owner_reqst && !mem_valid;

`ifdef PICORV_MEMARB_RR_EN
  logic [OW-1:0] ptr_q, ptr_d;
  assign pick_start = ptr_q;
  assign ptr_d = !take ? ptr_q :
                 (pick_winner == OW'(NREQ - 1)) ? '0 : pick_winner + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign pick_start = '0;
`endif

  picorv_memarb_pick #(.NREQ(NREQ), .OW(OW)) u_pick (
    .reqs   (req_reqst),
    .start  (pick_start),
    .found  (pick_found),
    .winner (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    take    = 1'b0;
    case (state_q)
      ARB_IDLE:  take = pick_found;
      ARB_OWNED: begin
        if (release_now) begin
          take = pick_found;
          if (!pick_found) begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      default:   state_d = ARB_IDLE;
    endcase
    if (take) begin
      state_d              = ARB_OWNED;
      owner_d              = pick_winner;
      grant_d              = '0;
      grant_d[pick_winner] = 1'b1;
    end
  end

  // Sticky: stray valid from a non-owner, or owner abandoning an unaccepted beat.
  assign err_d = err_q | (|(req_valid & ~grant_q))
               | (owned && !owner_reqst && mem_valid && !mem_ready);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_picorv_memarb.sv
// Self-checking bench for picorv_memarb: directed scenarios plus randomized
// traffic compared against a behavioural owner/pointer model.
module tb_picorv_memarb;

  localparam int XLEN  = 32;
  localparam int NREQ  = 2;
  localparam int OUT_W = 2 * NREQ + 1 + XLEN + 32 + 4 + 32 + 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_reqst, req_valid, req_grant, req_ready;
  logic [NREQ*XLEN-1:0] req_addr;
  logic [NREQ*32-1:0]   req_wdata;
  logic [NREQ*4-1:0]    req_wstrb;
  logic [31:0]          req_rdata, mem_wdata, mem_rdata;
  logic                 mem_valid, mem_ready, proto_err;
  logic [XLEN-1:0]      mem_addr;
  logic [3:0]           mem_wstrb;
  logic [OUT_W-1:0]     dut_out;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: current owner (-1 = none), rotate pointer, sticky error.
  int m_owner;
  int m_ptr;
  bit m_err;

  always #5 clock = ~clock;

  picorv_memarb #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_reqst (req_reqst),
    .req_grant (req_grant),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_rdata (req_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .proto_err (proto_err)
  );

  assign dut_out = {req_grant, req_ready, mem_valid, mem_addr, mem_wdata,
                    mem_wstrb, req_rdata, proto_err};

  function automatic logic [OUT_W-1:0] model_out();
    logic [NREQ-1:0] g, r;
    logic            mv;
    logic [XLEN-1:0] a;
    logic [31:0]     wd;
    logic [3:0]      ws;
    g = '0; r = '0; mv = 1'b0; a = '0; wd = '0; ws = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      mv         = req_valid[m_owner];
      a          = req_addr[m_owner*XLEN +: XLEN];
      wd         = req_wdata[m_owner*32 +: 32];
      ws         = req_wstrb[m_owner*4 +: 4];
      r[m_owner] = mem_ready & req_valid[m_owner];
    end
    return {g, r, mv, a, wd, ws, mem_rdata, m_err};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_err   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_next();
    int start;
    bit released;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && i != m_owner) m_err = 1'b1;
    if (m_owner >= 0 && !req_reqst[m_owner] && req_valid[m_owner] && !mem_ready)
      m_err = 1'b1;
    released = (m_owner < 0) || (!req_reqst[m_owner] && !req_valid[m_owner]);
    if (!released) return;
`ifdef PICORV_MEMARB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    m_owner = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (m_owner < 0 && req_reqst[(start + k) % NREQ]) begin
        m_owner = (start + k) % NREQ;
        m_ptr   = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic clk_step();
    model_next();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    req_reqst = '0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    req_reqst = '1;
    req_valid = '1;
    mem_ready = 1'b1;
    model_reset();
    @(negedge clock);
    #1;
    vectors++;
    if (req_grant !== '0 || mem_valid !== 1'b0 || proto_err !== 1'b0 ||
        req_ready !== '0 || mem_addr !== '0 || mem_wstrb !== '0) begin
      miscompares++;
      $display("FAIL reset: grant=%b valid=%b err=%b ready=%b addr=%h, want all zero",
               req_grant, mem_valid, proto_err, req_ready, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: req_reqst = 2'b10;
        1: begin
          req_valid[1]      = 1'b1;
          req_addr[XLEN +: XLEN] = 32'h100;
          req_wstrb[4 +: 4] = 4'h0;
          mem_rdata         = 32'h1234_5678;
        end
        3: begin
          mem_ready = 1'b1;
          mem_rdata = 32'hDEAD_BEEF;
        end
        4: begin
          req_valid = '0;
          req_reqst = '0;
          mem_ready = 1'b0;
        end
        default: ;
      endcase
      #1;
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("FAIL single c%0d: dut=%h model=%h", c, dut_out, model_out());
      end
      if (c == 0 || c == 1 || c == 5) begin
        vectors++;
        if (req_grant !== ((c == 1) ? 2'b10 : 2'b00)) begin
          miscompares++;
          $display("FAIL single_grant c%0d: grant=%b", c, req_grant);
        end
      end
      if (c == 2 || c == 3) begin
        vectors++;
        if (req_ready !== ((c == 3) ? 2'b10 : 2'b00) || req_rdata !== mem_rdata ||
            mem_addr !== 32'h100 || mem_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL single_read c%0d: ready=%b rdata=%h addr=%h valid=%b",
                   c, req_ready, req_rdata, mem_addr, mem_valid);
        end
      end
      clk_step();
    end
  endtask

  task automatic test_contention();
    logic [1:0] want [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: req_reqst = 2'b11;
        1: req_reqst = 2'b10;
        3: req_reqst = 2'b00;
        default: ;
      endcase
      #1;
      vectors++;
      if (dut_out !== model_out() || req_grant !== want[c]) begin
        miscompares++;
        $display("FAIL contention c%0d: grant=%b want=%b dut=%h model=%h",
                 c, req_grant, want[c], dut_out, model_out());
      end
      clk_step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ws_tab [3] = '{4'b1111, 4'b0011, 4'b1000};
    do_reset();
    req_reqst = 2'b11;
    clk_step();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        req_valid[0]      = 1'b1;
        req_addr[0 +: XLEN] = 32'h200 + 32'(c * 4);
        req_wdata[0 +: 32]  = $urandom();
        req_wstrb[0 +: 4]   = ws_tab[c];
        mem_ready         = 1'b1;
      end else begin
        req_reqst[0] = 1'b0;
        req_valid[0] = 1'b0;
        mem_ready    = 1'b0;
      end
      #1;
      vectors++;
      if (dut_out !== model_out() || req_grant !== ((c < 4) ? 2'b01 : 2'b10) ||
          (c < 3 && (mem_wstrb !== ws_tab[c] || mem_valid !== 1'b1 || req_ready !== 2'b01))) begin
        miscompares++;
        $display("FAIL burst c%0d: grant=%b wstrb=%b valid=%b dut=%h model=%h",
                 c, req_grant, mem_wstrb, mem_valid, dut_out, model_out());
      end
      clk_step();
    end
    req_reqst = '0;
    clk_step();
  endtask

  task automatic test_round_robin();
    int who;
    do_reset();
    req_reqst = 2'b11;
    clk_step();
    for (int k = 0; k < 4; k++) begin
      who = k % 2;
      req_reqst[1 - who] = 1'b1;
      req_valid[who]     = 1'b1;
      req_addr[who*XLEN +: XLEN] = $urandom();
      mem_ready          = 1'b1;
      #1;
      vectors++;
      if (dut_out !== model_out() || req_grant !== 2'(1 << who)) begin
        miscompares++;
        $display("FAIL rr_alternate k%0d: grant=%b want=%b", k, req_grant, 2'(1 << who));
      end
      clk_step();
      req_reqst[who] = 1'b0;
      req_valid[who] = 1'b0;
      mem_ready      = 1'b0;
      #1;
      clk_step();
    end
    req_reqst = '0;
    clk_step();
  endtask

  task automatic test_proto_err();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin req_valid = 2'b10; mem_ready = 1'b1; end
        1: begin req_valid = 2'b00; mem_ready = 1'b0; end
        2: req_reqst = 2'b01;
        3: begin
          req_valid = 2'b11;
          req_addr  = {32'hAAAA_0000, 32'h0000_0300};
          mem_ready = 1'b1;
        end
        4: begin req_reqst = '0; req_valid = '0; mem_ready = 1'b0; end
        default: ;
      endcase
      #1;
      vectors++;
      if (dut_out !== model_out() || proto_err !== (c != 0) ||
          (c == 0 && (mem_valid !== 1'b0 || req_ready !== 2'b00)) ||
          (c == 3 && (mem_addr !== 32'h300 || req_ready !== 2'b01))) begin
        miscompares++;
        $display("FAIL proto_err c%0d: err=%b valid=%b ready=%b addr=%h",
                 c, proto_err, mem_valid, req_ready, mem_addr);
      end
      clk_step();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_reqst = 2'b01;
    req_valid = 2'b10;
    clk_step();
    req_valid = 2'b01;
    req_addr[0 +: XLEN] = 32'h400;
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (dut_out !== model_out() || mem_valid !== 1'b1 || proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre: valid=%b err=%b", mem_valid, proto_err);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (dut_out !== model_out() || req_grant !== 2'b00 || mem_valid !== 1'b0 ||
        proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL areset: grant=%b valid=%b err=%b, want 00 0 0",
               req_grant, mem_valid, proto_err);
    end
    do_reset();
  endtask

  task automatic test_random(input bit wild);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) req_reqst[i] = ~req_reqst[i];
        if (wild) req_valid[i] = ($urandom_range(0, 3) == 0);
        else      req_valid[i] = (m_owner == i) && ($urandom_range(0, 1) == 1);
        req_addr[i*XLEN +: XLEN] = $urandom();
        req_wdata[i*32 +: 32]    = $urandom();
        req_wstrb[i*4 +: 4]      = 4'($urandom());
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom();
      #1;
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("FAIL random%0d c%0d: dut=%h model=%h", wild, c, dut_out, model_out());
      end
      clk_step();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_round_robin();
    test_proto_err();
    test_async_reset();
    test_random(1'b0);
    test_random(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
